spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- Parametrised SPI slave front-end for the single-port RAM subsystem; next generation of the fixed 10-bit SPI slave.
- Deserialises MOSI frames of width CMD+payload and presents them to the RAM controller with a one-cycle rx_valid strobe.
- Captures RAM read data on tx_valid and serialises it MSB-first on MISO.
- Address and data widths are independent parameters; adds an explicit read-wait state.

Parameters:
ADDR_W, 8, RAM address width.
DATA_W, 8, RAM data word width.
PAY_W, max(ADDR_W,DATA_W), payload width (derived localparam).
FRAME_W, PAY_W+2, frame width including 2-bit command (derived localparam).

Ports:
clk  in  1  serial clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
SS_n  in  1  slave select, active low; high aborts or terminates the frame.
MOSI  in  1  serial data in, sampled on clk rising edge.
MISO  out  1  serial data out.
din  out  FRAME_W  received frame: {cmd[1:0], payload}; payload right-justified.
rx_valid  out  1  one-cycle strobe; din is valid.
dout  in  DATA_W  read data from RAM.
tx_valid  in  1  dout valid; sampled only in READ_WAIT.

Behaviour:
- Reset values: MISO=0, din=0, rx_valid=0, state=IDLE, counters=0, shift registers=0.
- Command encoding in din[FRAME_W-1:FRAME_W-2]:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
  - Narrower fields use the low bits; unused high payload bits are passed through as received.
- FSM transitions (one per clk):
  - IDLE: SS_n=0 -> CHK_CMD; otherwise stay.
  - CHK_CMD: sample MOSI as the path bit. 0 -> WRITE, 1 -> READ_ADD. This bit is not stored.
  - WRITE / READ_ADD:
    - Shift MOSI into rx_shift MSB-first, one bit per clk, bit_cnt 0..FRAME_W-1.
    - On the clk that samples bit FRAME_W-1: din <= completed frame, rx_valid <= 1 for exactly the next cycle.
    - Further MOSI bits are ignored until SS_n rises.
    - READ_ADD only: if the completed frame has cmd==11, go to READ_WAIT. Otherwise stay until SS_n rises.
  - READ_WAIT:
    - MISO=0.
    - On the first clk with tx_valid=1: tx_shift <= dout, tx_cnt <= 0, go to READ_DATA.
    - Wait is unbounded.
  - READ_DATA:
    - MISO = tx_shift[DATA_W-1] (combinational from the register) while tx_cnt<DATA_W; otherwise 0.
    - Each clk shifts left and increments tx_cnt; bit k appears in the k-th READ_DATA cycle.
    - After DATA_W bits: MISO=0; hold state until SS_n rises.
- rx_valid is registered and never asserted outside the one cycle after a completed frame.
- din holds its last value until the next completed frame.
- SS_n=1 in any state: next state IDLE.
  - Counters cleared; partial rx_shift discarded.
  - No rx_valid for an incomplete frame; din unchanged.
  - MISO=0 from the next cycle.
- SS_n rising on the same clk as the last frame bit: frame counts as complete; rx_valid still pulses; state -> IDLE.
- tx_valid outside READ_WAIT is ignored.
- Back-to-back frames: a new SS_n low after one IDLE cycle starts cleanly.
- rst_n low mid-frame: all state to reset values immediately (async).
- Illegal state encodings -> IDLE.
- The WRITE path does not check cmd; the RAM controller decodes it.

Optional Feature:
- Macro: SPI_FRAME_ERR_EN.
- With the macro: extra output frame_err (1 bit, reset 0). It pulses for one cycle after SS_n is sampled high while in any of:
  - WRITE/READ_ADD with 0<bit_cnt<FRAME_W;
  - READ_WAIT;
  - READ_DATA with tx_cnt<DATA_W.
- No pulse in IDLE or CHK_CMD, or after complete transfers.
- Without the macro: port absent; behaviour otherwise identical.

Test Plan:
- ADDR_W=8, DATA_W=8; SS_n low, path bit 0, frame 10'b00_1010_0101 -> rx_valid single pulse one cycle after the 10th bit; din=10'h0A5; MISO stays 0.
- Same config; read-address frame 10'b10_0000_1111 then SS_n high; new frame, path bit 1, 10'b11_xxxx_xxxx; after 3 idle cycles tx_valid=1, dout=8'hC3 -> MISO sequence 1,1,0,0,0,0,1,1 on the 8 following cycles, then 0.
- ADDR_W=10, DATA_W=16 (FRAME_W=18); write-data frame {2'b01,16'hBEEF} -> din=18'h1BEEF; read-data with dout=16'h8001 -> MISO 1, fourteen 0s, 1.
- Abort: SS_n high after 5 payload bits -> no rx_valid; din keeps the previous value; state IDLE next cycle; with SPI_FRAME_ERR_EN, frame_err=1 for one cycle.
- rst_n low during READ_DATA bit 3 -> MISO=0, rx_valid=0, din=0 immediately; the next frame decodes correctly.
- tx_valid pulses in WRITE and READ_ADD -> ignored; MISO remains 0; no state change.

Source files
------------

// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave front-end for the single-port RAM subsystem.
// Receives {cmd[1:0], payload} frames MSB-first on MOSI after a path bit, and
// serialises RAM read data MSB-first on MISO once tx_valid arrives in READ_WAIT.
// Optional build macro SPI_FRAME_ERR_EN adds the frame_err abort indicator.
module spi_slave_param #(
    parameter  int unsigned ADDR_W  = 8,
    parameter  int unsigned DATA_W  = 8,
    localparam int unsigned PAY_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W,
    localparam int unsigned FRAME_W = PAY_W + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] din,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  dout,
    input  logic               tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic               frame_err
`endif
);

    localparam int unsigned BIT_CW = $clog2(FRAME_W + 1);
    localparam int unsigned TX_CW  = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_WAIT = 3'd4,
        READ_DATA = 3'd5
    } state_t;

    state_t              state;
    logic [FRAME_W-2:0]  rx_shift;
    logic [BIT_CW-1:0]   bit_cnt;
    logic [DATA_W-1:0]   tx_shift;
    logic [TX_CW-1:0]    tx_cnt;

    logic [FRAME_W-1:0]  frame_c;
    logic                last_bit_c;
    logic                rx_busy_c;
    logic                tx_busy_c;

    // Frame as it stands once the current MOSI bit is included.
    assign frame_c    = {rx_shift, MOSI};
    assign last_bit_c = (bit_cnt == BIT_CW'(FRAME_W - 1));
    assign rx_busy_c  = (bit_cnt < BIT_CW'(FRAME_W));
    assign tx_busy_c  = (tx_cnt < TX_CW'(DATA_W));

    // MISO drives the read-data MSB straight from the shift register while bits remain.
    assign MISO = (state == READ_DATA) && tx_busy_c && tx_shift[DATA_W-1];

    // Frame FSM, shift registers, counters and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            tx_cnt    <= '0;
            din       <= '0;
            rx_valid  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    rx_shift <= '0;
                    bit_cnt  <= '0;
                    tx_cnt   <= '0;
                    if (!SS_n) begin
                        state <= CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    if (SS_n) begin
                        state <= IDLE;
                    end else begin
                        state <= MOSI ? READ_ADD : WRITE;
                    end
                end

                WRITE, READ_ADD: begin
                    if (last_bit_c) begin
                        // Last bit completes the frame even if SS_n rises on this edge.
                        din      <= frame_c;
                        rx_valid <= 1'b1;
                        if (SS_n) begin
                            state    <= IDLE;
                            rx_shift <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            rx_shift <= frame_c[FRAME_W-2:0];
                            bit_cnt  <= bit_cnt + BIT_CW'(1);
                            if ((state == READ_ADD) && (frame_c[FRAME_W-1 -: 2] == 2'b11)) begin
                                state <= READ_WAIT;
                            end
                        end
                    end else if (SS_n) begin
                        state    <= IDLE;
                        rx_shift <= '0;
                        bit_cnt  <= '0;
`ifdef SPI_FRAME_ERR_EN
                        frame_err <= (bit_cnt != '0) && rx_busy_c;
`endif
                    end else if (rx_busy_c) begin
                        rx_shift <= frame_c[FRAME_W-2:0];
                        bit_cnt  <= bit_cnt + BIT_CW'(1);
                    end
                end

                READ_WAIT: begin
                    if (SS_n) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        tx_cnt  <= '0;
`ifdef SPI_FRAME_ERR_EN
                        frame_err <= 1'b1;
`endif
                    end else if (tx_valid) begin
                        tx_shift <= dout;
                        tx_cnt   <= '0;
                        state    <= READ_DATA;
                    end
                end

                READ_DATA: begin
                    if (SS_n) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        tx_cnt  <= '0;
`ifdef SPI_FRAME_ERR_EN
                        frame_err <= tx_busy_c;
`endif
                    end else if (tx_busy_c) begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        tx_cnt   <= tx_cnt + TX_CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: randomized self-checking bench for spi_slave_param.
// Two instances (8/8 and 10/16); transaction-level expectations per clock edge.
// Honours SPI_FRAME_ERR_EN to check the optional frame_err output.
module tb_spi_slave_param;

    localparam int NCYC = 16384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ss_n;
    logic [1:0]  mosi;
    logic [1:0]  tx_valid;
    logic [7:0]  dout0;
    logic [15:0] dout1;
    logic        miso0, miso1;
    logic        rxv0, rxv1;
    logic [9:0]  din0;
    logic [17:0] din1;
`ifdef SPI_FRAME_ERR_EN
    logic        err0, err1;
`endif

    spi_slave_param #(.ADDR_W(8), .DATA_W(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n[0]),
        .MOSI     (mosi[0]),
        .MISO     (miso0),
        .din      (din0),
        .rx_valid (rxv0),
        .dout     (dout0),
        .tx_valid (tx_valid[0])
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(err0)
`endif
    );

    spi_slave_param #(.ADDR_W(10), .DATA_W(16)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n[1]),
        .MOSI     (mosi[1]),
        .MISO     (miso1),
        .din      (din1),
        .rx_valid (rxv1),
        .dout     (dout1),
        .tx_valid (tx_valid[1])
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(err1)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter: value N means N rising edges have occurred.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after each edge, per instance.
    bit          exp_rxv  [2][NCYC];
    bit          exp_miso [2][NCYC];
    bit          exp_err  [2][NCYC];
    logic [17:0] exp_dinv [2][NCYC];
    logic [17:0] cur_din  [2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (edge %0d)", nm, act, req, cyc);
    endtask

    function automatic int fw_of(input int u);
        return (u == 0) ? 10 : 18;
    endfunction

    function automatic int dw_of(input int u);
        return (u == 0) ? 8 : 16;
    endfunction

    function automatic logic miso_of(input int u);
        return (u == 0) ? miso0 : miso1;
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // Drive one edge's inputs for instance u and advance past that edge.
    task automatic step(input int u, input bit ss, input bit mi, input bit tv, input logic [15:0] dv);
        if (cyc >= NCYC - 4) begin
            $display("FAIL cycle budget exhausted at edge %0d", cyc);
            $fatal(1, "cycle budget");
        end
        ss_n[u]     = ss;
        mosi[u]     = mi;
        tx_valid[u] = tv;
        if (u == 0) dout0 = dv[7:0];
        else        dout1 = dv;
        @(posedge clk);
        #1;
    endtask

    // Expectation setters for the upcoming edge.
    task automatic x_rxv(input int u, input logic [17:0] v);
        exp_rxv[u][cyc+1]  = 1'b1;
        exp_dinv[u][cyc+1] = v;
    endtask

    task automatic x_miso(input int u, input bit b);
        exp_miso[u][cyc+1] = b;
    endtask

    task automatic x_err(input int u);
        exp_err[u][cyc+1] = 1'b1;
    endtask

    // Select, path bit, then a full frame MSB-first; last_rise raises SS_n on the last bit.
    task automatic frame_bits(input int u, input bit path, input logic [17:0] frame,
                              input bit last_rise, input bit tv_force);
        int fw;
        fw = fw_of(u);
        step(u, 1'b0, rb(), tv_force | rb(), 16'($urandom));
        step(u, 1'b0, path, tv_force | rb(), 16'($urandom));
        for (int i = fw - 1; i >= 0; i--) begin
            if (i == 0) x_rxv(u, frame);
            step(u, (i == 0) ? last_rise : 1'b0, frame[i], tv_force | rb(), 16'($urandom));
        end
    endtask

    // Keep SS_n low for n more edges of ignored bits, then release (no error).
    task automatic hold_close(input int u, input int n, input bit tv_force);
        for (int i = 0; i < n; i++) step(u, 1'b0, rb(), tv_force | rb(), 16'($urandom));
        step(u, 1'b1, rb(), rb(), 16'($urandom));
    endtask

    // Abort: p<0 aborts in CHK_CMD, otherwise after p payload bits (p <= fw-2).
    task automatic abort_frame(input int u, input bit path, input int p);
        step(u, 1'b0, rb(), rb(), 16'($urandom));
        if (p >= 0) begin
            step(u, 1'b0, path, rb(), 16'($urandom));
            for (int k = 0; k < p; k++) step(u, 1'b0, rb(), rb(), 16'($urandom));
        end
        if (p > 0) x_err(u);
        step(u, 1'b1, rb(), rb(), 16'($urandom));
    endtask

    // From READ_WAIT: w idle edges, tx_valid with d, then release SS_n m edges later.
    task automatic read_xfer(input int u, input logic [15:0] d, input int w, input int m,
                             input bit wait_abort, output logic [15:0] cap);
        int dw;
        dw  = dw_of(u);
        cap = '0;
        for (int i = 0; i < w; i++) step(u, 1'b0, rb(), 1'b0, 16'($urandom));
        if (wait_abort) begin
            x_err(u);
            step(u, 1'b1, rb(), rb(), 16'($urandom));
            return;
        end
        x_miso(u, d[dw-1]);
        step(u, 1'b0, rb(), 1'b1, d);
        cap[dw-1] = miso_of(u);
        for (int k = 1; k < m; k++) begin
            if (k < dw) x_miso(u, d[dw-1-k]);
            step(u, 1'b0, rb(), rb(), 16'($urandom));
            if (k < dw) cap[dw-1-k] = miso_of(u);
        end
        if (m - 1 < dw) x_err(u);
        step(u, 1'b1, rb(), rb(), 16'($urandom));
    endtask

    task automatic gap(input int u, input int n);
        for (int i = 0; i < n; i++) step(u, 1'b1, rb(), rb(), 16'($urandom));
    endtask

    // Per-edge comparison of both instances against the expectation tables.
    always @(negedge clk) begin
        logic [17:0] act_din;
        logic        act_rxv;
        logic        act_miso;
        bit          live;
        if (cyc < NCYC) begin
            live = (rst_n === 1'b1);
            for (int u = 0; u < 2; u++) begin
                act_din  = (u == 0) ? 18'(din0) : din1;
                act_rxv  = (u == 0) ? rxv0 : rxv1;
                act_miso = miso_of(u);
                if (!live) cur_din[u] = '0;
                else if (exp_rxv[u][cyc]) cur_din[u] = exp_dinv[u][cyc];
                chk($sformatf("u%0d rx_valid", u), 32'(act_rxv), 32'(live && exp_rxv[u][cyc]));
                chk($sformatf("u%0d din", u), 32'(act_din), 32'(cur_din[u]));
                chk($sformatf("u%0d MISO", u), 32'(act_miso), 32'(live && exp_miso[u][cyc]));
`ifdef SPI_FRAME_ERR_EN
                chk($sformatf("u%0d frame_err", u), 32'((u == 0) ? err0 : err1),
                    32'(live && exp_err[u][cyc]));
`endif
            end
        end
    end

    // Directed scenarios followed by randomized transactions.
    initial begin
        logic [15:0] cap;
        logic [17:0] fr;
        int          u, fw, dw, kind, p;
        bit          path, lr;

        rst_n    = 1'b1;
        ss_n     = 2'b11;
        mosi     = 2'b00;
        tx_valid = 2'b00;
        dout0    = '0;
        dout1    = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset din u0", 32'(din0), 32'h0);
        chk("reset din u1", 32'(din1), 32'h0);
        chk("reset rx_valid u0", 32'(rxv0), 32'h0);
        chk("reset MISO u1", 32'(miso1), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        gap(0, 1);

        // Write-address frame 00_1010_0101 on the 8/8 instance.
        frame_bits(0, 1'b0, 18'h0A5, 1'b0, 1'b0);
        chk("write frame din u0", 32'(din0), 32'h0A5);
        chk("write frame rx_valid u0", 32'(rxv0), 32'h1);
        hold_close(0, 2, 1'b1);
        chk("rx_valid single pulse u0", 32'(rxv0), 32'h0);

        // Read address, then read data 8'hC3 after three wait cycles.
        frame_bits(0, 1'b1, 18'h20F, 1'b0, 1'b1);
        hold_close(0, 1, 1'b1);
        gap(0, 1);
        frame_bits(0, 1'b1, 18'h3A6, 1'b0, 1'b0);
        read_xfer(0, 16'h00C3, 3, 10, 1'b0, cap);
        chk("read C3 MISO sequence", 32'(cap[7:0]), 32'hC3);
        chk("read-data frame din u0", 32'(din0), 32'h3A6);

        // 10/16 instance: write-data BEEF, then read 16'h8001.
        frame_bits(1, 1'b0, 18'h1BEEF, 1'b0, 1'b0);
        chk("write BEEF din u1", 32'(din1), 32'h1BEEF);
        hold_close(1, 1, 1'b0);
        frame_bits(1, 1'b1, 18'h30123, 1'b0, 1'b0);
        read_xfer(1, 16'h8001, 0, 18, 1'b0, cap);
        chk("read 8001 MISO sequence", 32'(cap), 32'h8001);

        // Abort after 5 payload bits: din keeps its value.
        abort_frame(0, 1'b0, 5);
        chk("abort keeps din u0", 32'(din0), 32'h3A6);
        chk("abort no rx_valid u0", 32'(rxv0), 32'h0);
`ifdef SPI_FRAME_ERR_EN
        chk("abort frame_err u0", 32'(err0), 32'h1);
`endif
        // SS_n rising with the last bit of a read-data frame: completes, returns to IDLE.
        frame_bits(0, 1'b1, 18'h3FF, 1'b1, 1'b0);
        chk("last-bit rise din u0", 32'(din0), 32'h3FF);
        frame_bits(0, 1'b0, 18'h155, 1'b0, 1'b0);
        hold_close(0, 0, 1'b0);
        chk("frame after last-bit rise", 32'(din0), 32'h155);

        // Asynchronous reset while bit 3 of read data 8'hF0 is on MISO.
        frame_bits(0, 1'b1, 18'h3C5, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 16'h0);
        x_miso(0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1, 16'h00F0);
        x_miso(0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, 16'h0);
        x_miso(0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, 16'h0);
        x_miso(0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("MISO bit3 before reset", 32'(miso0), 32'h1);
        ss_n[0] = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("reset mid-read MISO", 32'(miso0), 32'h0);
        chk("reset mid-read rx_valid", 32'(rxv0), 32'h0);
        chk("reset mid-read din", 32'(din0), 32'h0);
        gap(0, 2);
        rst_n = 1'b1;
        gap(0, 1);
        frame_bits(0, 1'b0, 18'h2B4, 1'b0, 1'b0);
        hold_close(0, 1, 1'b0);
        chk("frame after reset din u0", 32'(din0), 32'h2B4);

        // Randomized transactions on both instances.
        for (int it = 0; it < 200; it++) begin
            u    = int'($urandom_range(0, 1));
            fw   = fw_of(u);
            dw   = dw_of(u);
            path = rb();
            kind = int'($urandom_range(0, 3));
            fr   = 18'($urandom) & 18'((1 << fw) - 1);
            if (kind == 0) begin
                p = int'($urandom_range(0, fw - 1)) - 1;
                abort_frame(u, path, p);
            end else begin
                if (kind == 3) begin
                    path = 1'b1;
                    fr[fw-1 -: 2] = 2'b11;
                end
                lr = ($urandom_range(0, 3) == 0);
                frame_bits(u, path, fr, lr, 1'b0);
                if (!lr) begin
                    if (path && fr[fw-1] && fr[fw-2]) begin
                        read_xfer(u, 16'($urandom) & 16'((1 << dw) - 1),
                                  int'($urandom_range(0, 4)), int'($urandom_range(1, dw + 2)),
                                  ($urandom_range(0, 7) == 0), cap);
                    end else begin
                        hold_close(u, int'($urandom_range(0, 3)), 1'b0);
                    end
                end
            end
            gap(u, int'($urandom_range(0, 2)));
        end

        gap(0, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
